// File: rtl/soldier_spawn_scheduler_if.sv
// Spawn-scheduler bus: requester pulses, game tick, Queue push/pop/size and status.
// master drives the inputs (requesters/Queue side), slave is the scheduler.
interface soldier_spawn_scheduler_if;
    localparam int unsigned NREQ = 2;
    localparam int unsigned SZ_W = 5;
    localparam int unsigned EN_W = 7;

    logic            tick;
    logic [NREQ-1:0] req;
    logic            front_done;
    logic [SZ_W-1:0] size;
    logic            push;
    logic            pop;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] reject;
    logic [EN_W-1:0] energy;
    logic [NREQ-1:0] cooling;

    modport master (
        output tick, req, front_done, size,
        input  push, pop, grant, reject, energy, cooling
    );

    modport slave (
        input  tick, req, front_done, size,
        output push, pop, grant, reject, energy, cooling
    );
endinterface

// File: rtl/soldier_spawn_scheduler.sv
// Turns spawn/remove events into one-cycle Queue push/pop strobes with cooldown and energy gating.
// Define SPAWN_ENERGY_EN to enable the shared energy budget; otherwise energy reads 0.
module soldier_spawn_scheduler #(
    parameter int unsigned QDEPTH     = 16,
    parameter int unsigned COOLDOWN   = 8,
    parameter int unsigned COST       = 10,
    parameter int unsigned ENERGY_INC = 1,
    parameter int unsigned ENERGY_MAX = 99
) (
    input  logic                       clk,
    input  logic                       rst,
    soldier_spawn_scheduler_if.slave   bus
);
    localparam int unsigned NREQ = 2;
    localparam int unsigned CD_W = 4;
    localparam int unsigned EN_W = 7;
    localparam int unsigned EW1  = EN_W + 1;
    localparam int unsigned SZ_W = 5;

    // Reject configurations that cannot be represented in the fixed port/counter widths.
    if (QDEPTH >= (1 << SZ_W) || COOLDOWN >= (1 << CD_W) || ENERGY_MAX >= (1 << EN_W) ||
        COST > ENERGY_MAX || ENERGY_INC > ENERGY_MAX) begin : g_bad_cfg
        $error("soldier_spawn_scheduler: parameter out of range");
    end

    typedef enum logic {IDLE, SETTLE} state_e;

    state_e                     state_q, state_d;
    logic                       push_q, push_d;
    logic                       pop_q, pop_d;
    logic [NREQ-1:0]            grant_q, grant_d;
    logic [NREQ-1:0]            reject_q, reject_d;
    logic [NREQ-1:0]            pend_q, pend_d;
    logic                       pop_pend_q, pop_pend_d;
    logic                       rr_last_q, rr_last_d;
    logic [NREQ-1:0][CD_W-1:0]  cd_q, cd_d;
    logic [NREQ-1:0]            cooling_q, cooling_d;

    logic [NREQ-1:0]            grant_vec;
    logic [NREQ-1:0]            elig;
    logic [NREQ-1:0]            cd_zero;
    logic                       energy_ok;
    logic                       size_ok;
    logic                       pop_clr;
    logic                       sel;

`ifdef SPAWN_ENERGY_EN
    logic [EN_W-1:0]            energy_q, energy_d;
    logic [EW1-1:0]             e_sum;

    // Grant only happens with energy >= COST, so the subtraction cannot wrap.
    always_comb begin
        e_sum = EW1'(energy_q);
        if (grant_vec != '0) e_sum = e_sum - EW1'(COST);
        if (bus.tick)        e_sum = e_sum + EW1'(ENERGY_INC);
        energy_d = (e_sum > EW1'(ENERGY_MAX)) ? EN_W'(ENERGY_MAX) : e_sum[EN_W-1:0];
    end

    assign energy_ok  = (energy_q >= EN_W'(COST));
    assign bus.energy = energy_q;
`else
    assign energy_ok  = 1'b1;
    assign bus.energy = '0;
`endif

    assign size_ok = (bus.size < SZ_W'(QDEPTH));
    assign cd_zero = {cd_q[1] == '0, cd_q[0] == '0};
    assign elig    = pend_q & cd_zero & {NREQ{energy_ok}} & {NREQ{size_ok}};

    // Next-state: arbitration, pending bookkeeping and cooldown counters.
    always_comb begin
        state_d    = state_q;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        grant_vec  = '0;
        pop_clr    = 1'b0;
        sel        = 1'b0;
        rr_last_d  = rr_last_q;

        case (state_q)
            IDLE: begin
                if (pop_pend_q) begin
                    pop_clr = 1'b1;
                    if (bus.size != '0) begin
                        pop_d   = 1'b1;
                        state_d = SETTLE;
                    end
                end else if (elig != '0) begin
                    sel       = (elig == 2'b11) ? ~rr_last_q : elig[1];
                    grant_vec = sel ? 2'b10 : 2'b01;
                    push_d    = 1'b1;
                    rr_last_d = sel;
                    state_d   = SETTLE;
                end
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        grant_d    = grant_vec;
        reject_d   = bus.req & pend_q;
        pend_d     = (pend_q & ~grant_vec) | (bus.req & ~pend_q);
        pop_pend_d = (pop_pend_q & ~pop_clr) | bus.front_done;

        for (int i = 0; i < NREQ; i++) begin
            cd_d[i] = cd_q[i];
            if (bus.tick && cd_q[i] != '0) cd_d[i] = cd_q[i] - CD_W'(1);
            if (grant_vec[i])              cd_d[i] = CD_W'(COOLDOWN);
        end
        cooling_d = {cd_d[1] != '0, cd_d[0] != '0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            grant_q    <= '0;
            reject_q   <= '0;
            pend_q     <= '0;
            pop_pend_q <= 1'b0;
            rr_last_q  <= 1'b1;
            cd_q       <= '0;
            cooling_q  <= '0;
`ifdef SPAWN_ENERGY_EN
            energy_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            grant_q    <= grant_d;
            reject_q   <= reject_d;
            pend_q     <= pend_d;
            pop_pend_q <= pop_pend_d;
            rr_last_q  <= rr_last_d;
            cd_q       <= cd_d;
            cooling_q  <= cooling_d;
`ifdef SPAWN_ENERGY_EN
            energy_q   <= energy_d;
`endif
        end
    end

    assign bus.push    = push_q;
    assign bus.pop     = pop_q;
    assign bus.grant   = grant_q;
    assign bus.reject  = reject_q;
    assign bus.cooling = cooling_q;
endmodule
